// File: rtl/wb_pkg.sv
// wb_pkg: shared types, widths and load extension helper for the writeback arbiter.
package wb_pkg;

    localparam int REGISTER_WIDTH = 64;
    localparam int REGISTERNO_WIDTH = 5;

    typedef enum logic [1:0] {LD_B, LD_H, LD_W, LD_D} ld_size_e;

    typedef struct packed {
        logic [REGISTERNO_WIDTH-1:0] rd;
        logic [REGISTER_WIDTH-1:0]   data;
        ld_size_e                    size;
        logic                        is_unsigned;
    } ld_entry_t;

    typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LD} wb_src_e;

    // Keep the low bytes selected by size; fill above with zeros or the kept sign bit.
    function automatic logic [REGISTER_WIDTH-1:0] ld_extend(input ld_entry_t e);
        logic [REGISTER_WIDTH-1:0] d;
        logic u;
        d = e.data;
        u = e.is_unsigned;
        return e.size == LD_B ? {{(REGISTER_WIDTH-8){~u & d[7]}}, d[7:0]} :
               e.size == LD_H ? {{(REGISTER_WIDTH-16){~u & d[15]}}, d[15:0]} :
               e.size == LD_W ? {{(REGISTER_WIDTH-32){~u & d[31]}}, d[31:0]} : d;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: ALU/load producer handshakes and register-file write port.
interface writeback_arbiter_if import wb_pkg::*; ();

    logic                        alu_valid;
    logic                        alu_ready;
    logic [REGISTERNO_WIDTH-1:0] alu_rd;
    logic [REGISTER_WIDTH-1:0]   alu_value;
    logic                        ld_valid;
    logic                        ld_ready;
    logic [REGISTERNO_WIDTH-1:0] ld_rd;
    logic [REGISTER_WIDTH-1:0]   ld_data;
    logic [1:0]                  ld_size;
    logic                        ld_unsigned;
    logic                        wr_enable;
    logic [REGISTERNO_WIDTH-1:0] rd_regno;
    logic [REGISTER_WIDTH-1:0]   rd_value;
    logic                        busy;

    modport master (
        output alu_valid, alu_rd, alu_value, ld_valid, ld_rd, ld_data, ld_size, ld_unsigned,
        input  alu_ready, ld_ready, wr_enable, rd_regno, rd_value, busy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_value, ld_valid, ld_rd, ld_data, ld_size, ld_unsigned,
        output alu_ready, ld_ready, wr_enable, rd_regno, rd_value, busy
    );

endinterface

// File: rtl/wb_ld_fifo.sv
// wb_ld_fifo: synchronous FIFO of load-return entries with full/empty/count.
module wb_ld_fifo import wb_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  ld_entry_t                    i_din,
    input  logic                         i_pop,
    output ld_entry_t                    o_dout,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    ld_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= AW'((int'(r_wr_ptr) + 1) % DEPTH);
            if (w_pop) r_rd_ptr <= AW'((int'(r_rd_ptr) + 1) % DEPTH);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU results and buffered, extended loads onto one register-file write port.
// Optional WB_STATS_EN adds free-running grant counters.
module writeback_arbiter import wb_pkg::*; #(
    parameter int LD_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    writeback_arbiter_if.slave        bus
`ifdef WB_STATS_EN
    ,
    output logic [31:0]               stat_alu_writes,
    output logic [31:0]               stat_ld_writes,
    output logic [31:0]               stat_forced
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT+1);
    localparam int CW = $clog2(LD_FIFO_DEPTH+1);

    ld_entry_t                   w_din;
    ld_entry_t                   w_head;
    logic                        w_full;
    logic                        w_empty;
    logic [CW-1:0]               w_count;
    logic                        w_force;
    wb_src_e                     w_src;
    logic [REGISTERNO_WIDTH-1:0] w_wr_rd;
    logic [REGISTER_WIDTH-1:0]   w_wr_value;
    logic                        w_wr;
    logic [SW-1:0]               r_starve;
    logic                        r_wr_enable;
    logic [REGISTERNO_WIDTH-1:0] r_rd_regno;
    logic [REGISTER_WIDTH-1:0]   r_rd_value;

    always_comb begin
        w_din      = '{rd: bus.ld_rd, data: bus.ld_data, size: ld_size_e'(bus.ld_size), is_unsigned: bus.ld_unsigned};
        w_force    = bus.alu_valid && r_starve == SW'(STARVE_LIMIT);
        w_src      = reset ? SRC_NONE : (!w_empty && !w_force) ? SRC_LD : bus.alu_valid ? SRC_ALU : SRC_NONE;
        w_wr_rd    = w_src == SRC_LD ? w_head.rd : bus.alu_rd;
        w_wr_value = w_src == SRC_LD ? ld_extend(w_head) : bus.alu_value;
        w_wr       = w_src != SRC_NONE && w_wr_rd != '0;
    end

    assign bus.alu_ready = w_src == SRC_ALU;
    assign bus.ld_ready  = !reset && !w_full;
    assign bus.wr_enable = r_wr_enable;
    assign bus.rd_regno  = r_rd_regno;
    assign bus.rd_value  = r_rd_value;
    assign bus.busy      = w_count != '0 || r_wr_enable;

    wb_ld_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (bus.ld_valid && bus.ld_ready),
        .i_din   (w_din),
        .i_pop   (w_src == SRC_LD),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Counts consecutive denied ALU cycles; hitting the limit forces the next ALU grant.
    always_ff @(posedge clk) begin
        if (reset || !bus.alu_valid || bus.alu_ready) r_starve <= '0;
        else if (r_starve != SW'(STARVE_LIMIT)) r_starve <= r_starve + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_enable <= 1'b0;
            r_rd_regno  <= '0;
            r_rd_value  <= '0;
        end else begin
            r_wr_enable <= w_wr;
            if (w_wr) begin
                r_rd_regno <= w_wr_rd;
                r_rd_value <= w_wr_value;
            end
        end
    end

`ifdef WB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_alu_writes <= '0;
            stat_ld_writes  <= '0;
            stat_forced     <= '0;
        end else begin
            stat_alu_writes <= stat_alu_writes + 32'(w_src == SRC_ALU);
            stat_ld_writes  <= stat_ld_writes + 32'(w_src == SRC_LD);
            stat_forced     <= stat_forced + 32'(w_src == SRC_ALU && w_force);
        end
    end
`endif

endmodule
